// File: rtl/duck_round_ctrl_if.sv
// Handshake bundle between the gun/trigger logic, duck_round_ctrl and the
// duck motion / HUD blocks. The optional score output is present only when
// DUCK_SCORE_EN is defined.
interface duck_round_ctrl_if #(
   parameter int DUCKS_PER_ROUND = 10
);
   logic                       frame_clk;
   logic                       start;
   logic                       fire;
   logic                       hit;
   logic                       duck_spawn;
   logic                       duck_active;
   logic                       duck_falling;
   logic                       duck_escape;
   logic [1:0]                 shots_left;
   logic [3:0]                 duck_num;
   logic [3:0]                 hit_count;
   logic [DUCKS_PER_ROUND-1:0] hit_map;
   logic                       round_done;
`ifdef DUCK_SCORE_EN
   logic [15:0]                score;
`endif

   modport master (
      output frame_clk, start, fire, hit,
`ifdef DUCK_SCORE_EN
      input  score,
`endif
      input  duck_spawn, duck_active, duck_falling, duck_escape,
      input  shots_left, duck_num, hit_count, hit_map, round_done
   );

   modport slave (
      input  frame_clk, start, fire, hit,
`ifdef DUCK_SCORE_EN
      output score,
`endif
      output duck_spawn, duck_active, duck_falling, duck_escape,
      output shots_left, duck_num, hit_count, hit_map, round_done
   );
endinterface

// File: rtl/duck_round_ctrl.sv
// duck_round_ctrl: round sequencer for the duck sprite datapath. Spawns each
// duck, times the launch/fly/pause/fall/escape phases in frame ticks, and
// judges gun shots against the duck hit flag.
// Optional feature macro: DUCK_SCORE_EN adds a saturating 16-bit score.
module duck_round_ctrl #(
   parameter int DUCKS_PER_ROUND = 10,
   parameter int SHOTS_PER_DUCK  = 3,
   parameter int LAUNCH_FRAMES   = 30,
   parameter int FLY_FRAMES      = 300,
   parameter int PAUSE_FRAMES    = 30,
   parameter int FALL_FRAMES     = 60,
   parameter int ESCAPE_FRAMES   = 60
) (
   input logic              Clk,
   input logic              Reset_n,
   duck_round_ctrl_if.slave bus
);

   typedef enum logic [2:0] {IDLE, LAUNCH, FLY, PAUSE, FALL, ESCAPE, NEXT, DONE} state_t;

   // Timers hold N-1 so that expiry (tick while zero) lands on the Nth tick.
   localparam logic [9:0] LAUNCH_LOAD = 10'(LAUNCH_FRAMES - 1);
   localparam logic [9:0] FLY_LOAD    = 10'(FLY_FRAMES - 1);
   localparam logic [9:0] PAUSE_LOAD  = 10'(PAUSE_FRAMES - 1);
   localparam logic [9:0] FALL_LOAD   = 10'(FALL_FRAMES - 1);
   localparam logic [9:0] ESCAPE_LOAD = 10'(ESCAPE_FRAMES - 1);
   localparam logic [1:0] SHOTS_INIT  = 2'(SHOTS_PER_DUCK);
   localparam logic [3:0] LAST_DUCK   = 4'(DUCKS_PER_ROUND - 1);
   localparam logic [3:0] ALL_HIT     = 4'(DUCKS_PER_ROUND);
   localparam logic [DUCKS_PER_ROUND-1:0] MAP_ONE = {{(DUCKS_PER_ROUND-1){1'b0}}, 1'b1};

`ifdef DUCK_SCORE_EN
   function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

   logic [15:0] score;
`endif

   state_t                     state;
   logic [9:0]                 timer;
   logic                       frame_p0;
   logic                       frame_p1;
   logic                       tick;
   logic                       expire;
   logic                       duck_spawn;
   logic                       duck_active;
   logic                       duck_falling;
   logic                       duck_escape;
   logic [1:0]                 shots_left;
   logic [3:0]                 duck_num;
   logic [3:0]                 hit_count;
   logic [DUCKS_PER_ROUND-1:0] hit_map;
   logic                       round_done;

   assign tick   = frame_p0 & ~frame_p1;
   assign expire = tick && (timer == 10'd0);

   // Bring the VGA frame strobe into the Clk domain for rising-edge detection.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         frame_p0 <= 1'b0;
         frame_p1 <= 1'b0;
      end else begin
         frame_p0 <= bus.frame_clk;
         frame_p1 <= frame_p0;
      end
   end

   // Round FSM; every output flag is set on the transition edge so it is
   // already registered when the new state begins.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state        <= IDLE;
         timer        <= 10'd0;
         duck_spawn   <= 1'b0;
         duck_active  <= 1'b0;
         duck_falling <= 1'b0;
         duck_escape  <= 1'b0;
         shots_left   <= SHOTS_INIT;
         duck_num     <= 4'd0;
         hit_count    <= 4'd0;
         hit_map      <= '0;
         round_done   <= 1'b0;
`ifdef DUCK_SCORE_EN
         score        <= 16'd0;
`endif
      end else begin
         duck_spawn <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  state      <= LAUNCH;
                  timer      <= LAUNCH_LOAD;
                  duck_spawn <= 1'b1;
                  shots_left <= SHOTS_INIT;
                  duck_num   <= 4'd0;
                  hit_count  <= 4'd0;
                  hit_map    <= '0;
                  round_done <= 1'b0;
`ifdef DUCK_SCORE_EN
                  score      <= 16'd0;
`endif
               end
            end
            LAUNCH: begin
               if (expire) begin
                  state       <= FLY;
                  timer       <= FLY_LOAD;
                  duck_active <= 1'b1;
               end else if (tick) begin
                  timer <= timer - 10'd1;
               end
            end
            FLY: begin
               // A shot is judged before the flight timer; a coinciding expiry is dropped.
               if (bus.fire) begin
                  if (bus.hit) begin
                     state        <= PAUSE;
                     timer        <= PAUSE_LOAD;
                     duck_active  <= 1'b0;
                     duck_falling <= 1'b1;
                     hit_map      <= hit_map | (MAP_ONE << duck_num);
                     hit_count    <= hit_count + 4'd1;
`ifdef DUCK_SCORE_EN
                     score        <= sat_add(score, 16'd500);
`endif
                  end else if (shots_left > 2'd1) begin
                     shots_left <= shots_left - 2'd1;
                     if (tick && (timer != 10'd0)) begin
                        timer <= timer - 10'd1;
                     end
                  end else begin
                     shots_left  <= 2'd0;
                     state       <= ESCAPE;
                     timer       <= ESCAPE_LOAD;
                     duck_active <= 1'b0;
                     duck_escape <= 1'b1;
                  end
               end else if (expire) begin
                  state       <= ESCAPE;
                  timer       <= ESCAPE_LOAD;
                  duck_active <= 1'b0;
                  duck_escape <= 1'b1;
               end else if (tick) begin
                  timer <= timer - 10'd1;
               end
            end
            PAUSE: begin
               if (expire) begin
                  state <= FALL;
                  timer <= FALL_LOAD;
               end else if (tick) begin
                  timer <= timer - 10'd1;
               end
            end
            FALL: begin
               if (expire) begin
                  state        <= NEXT;
                  duck_falling <= 1'b0;
               end else if (tick) begin
                  timer <= timer - 10'd1;
               end
            end
            ESCAPE: begin
               if (expire) begin
                  state       <= NEXT;
                  duck_escape <= 1'b0;
               end else if (tick) begin
                  timer <= timer - 10'd1;
               end
            end
            NEXT: begin
               if (duck_num == LAST_DUCK) begin
                  state      <= DONE;
                  round_done <= 1'b1;
`ifdef DUCK_SCORE_EN
                  if (hit_count == ALL_HIT) begin
                     score <= sat_add(score, 16'd1000);
                  end
`endif
               end else begin
                  state      <= LAUNCH;
                  timer      <= LAUNCH_LOAD;
                  duck_spawn <= 1'b1;
                  shots_left <= SHOTS_INIT;
                  duck_num   <= duck_num + 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.duck_spawn   = duck_spawn;
   assign bus.duck_active  = duck_active;
   assign bus.duck_falling = duck_falling;
   assign bus.duck_escape  = duck_escape;
   assign bus.shots_left   = shots_left;
   assign bus.duck_num     = duck_num;
   assign bus.hit_count    = hit_count;
   assign bus.hit_map      = hit_map;
   assign bus.round_done   = round_done;
`ifdef DUCK_SCORE_EN
   assign bus.score        = score;
`endif

endmodule

// File: tb/tb_duck_round_ctrl.sv
// Bench for duck_round_ctrl: directed round scenarios against a phase-level
// reference model of the round rules.
module tb_duck_round_ctrl;
   localparam int DUCKS    = 10;
   localparam int SHOTS    = 3;
   localparam int LAUNCH_N = 30;
   localparam int FLY_N    = 300;
   localparam int PAUSE_N  = 30;
   localparam int FALL_N   = 60;
   localparam int ESC_N    = 60;

   localparam int P_IDLE = 0, P_LAUNCH = 1, P_FLY = 2, P_PAUSE = 3,
                  P_FALL = 4, P_ESC = 5, P_NEXT = 6, P_DONE = 7;

   logic Clk = 1'b0;
   logic Reset_n = 1'b0;
   int   nvec = 0;
   int   nerr = 0;

   duck_round_ctrl_if #(.DUCKS_PER_ROUND(DUCKS)) bus ();

   duck_round_ctrl #(
      .DUCKS_PER_ROUND(DUCKS), .SHOTS_PER_DUCK(SHOTS), .LAUNCH_FRAMES(LAUNCH_N),
      .FLY_FRAMES(FLY_N), .PAUSE_FRAMES(PAUSE_N), .FALL_FRAMES(FALL_N),
      .ESCAPE_FRAMES(ESC_N)
   ) dut (
      .Clk(Clk),
      .Reset_n(Reset_n),
      .bus(bus)
   );

   always #10 Clk = ~Clk;

   // Frame strobe: one rising edge every 4 Clk cycles
   initial begin
      bus.frame_clk = 1'b0;
      forever begin
         repeat (2) @(negedge Clk);
         bus.frame_clk = ~bus.frame_clk;
      end
   end

   // ---------------- reference model ----------------
   int              m_phase = P_IDLE;
   int              m_rem   = 0;
   int              m_duck  = 0;
   int              m_hits  = 0;
   int              m_shots = SHOTS;
   int              m_score = 0;
   logic [DUCKS-1:0] m_map  = '0;
   logic            m_spawn = 1'b0;
   logic            ms1 = 1'b0;
   logic            ms2 = 1'b0;
   logic            tick_now;
   assign tick_now = ms1 & ~ms2;

   initial begin : model
      logic t;
      forever begin
         @(posedge Clk or negedge Reset_n);
         if (!Reset_n) begin
            m_phase = P_IDLE; m_rem = 0; m_duck = 0; m_hits = 0; m_shots = SHOTS;
            m_score = 0; m_map = '0; m_spawn = 1'b0; ms1 = 1'b0; ms2 = 1'b0;
         end else begin
            t = ms1 & ~ms2;
            ms2 = ms1;
            ms1 = bus.frame_clk;
            m_spawn = 1'b0;
            case (m_phase)
               P_IDLE, P_DONE: if (bus.start) begin
                  m_duck = 0; m_hits = 0; m_map = '0; m_score = 0;
                  m_phase = P_LAUNCH; m_rem = LAUNCH_N; m_spawn = 1'b1; m_shots = SHOTS;
               end
               P_LAUNCH: if (t) begin
                  m_rem--;
                  if (m_rem == 0) begin m_phase = P_FLY; m_rem = FLY_N; end
               end
               P_FLY: begin
                  if (bus.fire) begin
                     if (bus.hit) begin
                        m_phase = P_PAUSE; m_rem = PAUSE_N; m_map[m_duck] = 1'b1; m_hits++;
                        m_score = (m_score + 500 > 65535) ? 65535 : m_score + 500;
                     end else if (m_shots > 1) begin
                        m_shots--;
                        if (t && m_rem > 1) m_rem--;
                     end else begin
                        m_shots = 0; m_phase = P_ESC; m_rem = ESC_N;
                     end
                  end else if (t) begin
                     m_rem--;
                     if (m_rem == 0) begin m_phase = P_ESC; m_rem = ESC_N; end
                  end
               end
               P_PAUSE: if (t) begin
                  m_rem--;
                  if (m_rem == 0) begin m_phase = P_FALL; m_rem = FALL_N; end
               end
               P_FALL, P_ESC: if (t) begin
                  m_rem--;
                  if (m_rem == 0) m_phase = P_NEXT;
               end
               P_NEXT: begin
                  if (m_duck == DUCKS - 1) begin
                     m_phase = P_DONE;
                     if (m_hits == DUCKS) m_score = (m_score + 1000 > 65535) ? 65535 : m_score + 1000;
                  end else begin
                     m_duck++;
                     m_phase = P_LAUNCH; m_rem = LAUNCH_N; m_spawn = 1'b1; m_shots = SHOTS;
                  end
               end
               default: m_phase = P_IDLE;
            endcase
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Every cycle: DUT outputs against the model
   initial begin
      forever begin
         @(negedge Clk);
         check("duck_spawn",   32'(bus.duck_spawn),   32'(m_spawn));
         check("duck_active",  32'(bus.duck_active),  32'(m_phase == P_FLY));
         check("duck_falling", 32'(bus.duck_falling), 32'(m_phase == P_PAUSE || m_phase == P_FALL));
         check("duck_escape",  32'(bus.duck_escape),  32'(m_phase == P_ESC));
         check("round_done",   32'(bus.round_done),   32'(m_phase == P_DONE));
         check("shots_left",   32'(bus.shots_left),   32'(m_shots));
         check("duck_num",     32'(bus.duck_num),     32'(m_duck));
         check("hit_count",    32'(bus.hit_count),    32'(m_hits));
         check("hit_map",      32'(bus.hit_map),      32'(m_map));
`ifdef DUCK_SCORE_EN
         check("score",        32'(bus.score),        32'(m_score));
`endif
      end
   end

   // ---------------- stimulus helpers ----------------
   function automatic logic sig(input int w);
      case (w)
         0: return bus.duck_active;
         1: return bus.duck_escape;
         2: return bus.duck_falling;
         3: return bus.round_done;
         4: return bus.duck_spawn;
         default: return 1'b0;
      endcase
   endfunction

   task automatic wait_sig(input int w, input string name);
      int n = 0;
      while (!sig(w) && n < 5000) begin
         @(negedge Clk);
         n++;
      end
      check({name, " reached"}, 32'(sig(w)), 32'd1);
   endtask

   // Count frame ticks consumed while a flag is high
   task automatic measure(input int w, input string name, input int exp);
      int cnt = 0;
      int n = 0;
      wait_sig(w, name);
      while (sig(w) && n < 5000) begin
         if (tick_now) cnt++;
         @(negedge Clk);
         n++;
      end
      check(name, 32'(cnt), 32'(exp));
   endtask

   // Fire in the cycle that carries the nth flight tick counted from now
   task automatic fly_fire(input int nth, input logic h);
      int cnt = 0;
      int n = 0;
      wait_sig(0, "fly");
      while (n < 5000) begin
         if (tick_now) cnt++;
         if (cnt >= nth) break;
         @(negedge Clk);
         n++;
      end
      bus.fire = 1'b1;
      bus.hit  = h;
      @(negedge Clk);
      bus.fire = 1'b0;
      bus.hit  = 1'b0;
   endtask

   task automatic three_miss(input int hits_so_far);
      fly_fire(2, 1'b0);
      check("shots after miss 1", 32'(bus.shots_left), 32'd2);
      fly_fire(2, 1'b0);
      check("shots after miss 2", 32'(bus.shots_left), 32'd1);
      fly_fire(2, 1'b0);
      check("shots after miss 3", 32'(bus.shots_left), 32'd0);
      check("escape after miss 3", 32'(bus.duck_escape), 32'd1);
      bus.fire = 1'b1;
      bus.hit  = 1'b1;
      @(negedge Clk);
      bus.fire = 1'b0;
      bus.hit  = 1'b0;
      check("shots after stray fire", 32'(bus.shots_left), 32'd0);
      check("hits after stray fire", 32'(bus.hit_count), 32'(hits_so_far));
      check("escape after stray fire", 32'(bus.duck_escape), 32'd1);
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      @(negedge Clk);
      bus.start = 1'b0;
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      bus.start = 1'b0;
      bus.fire  = 1'b0;
      bus.hit   = 1'b0;
      repeat (3) @(negedge Clk);
      check("reset shots_left", 32'(bus.shots_left), 32'd3);
      check("reset duck_active", 32'(bus.duck_active), 32'd0);
      check("reset round_done", 32'(bus.round_done), 32'd0);
      Reset_n = 1'b1;
      repeat (4) @(negedge Clk);
      check("idle holds", 32'(bus.duck_spawn), 32'd0);

      // No fire: full flight then escape, then next duck spawns
      pulse_start();
      check("spawn after start", 32'(bus.duck_spawn), 32'd1);
      check("duck 0 first", 32'(bus.duck_num), 32'd0);
      measure(0, "fly ticks", 300);
      measure(1, "escape ticks", 60);
      wait_sig(4, "second spawn");
      check("duck_num after escape", 32'(bus.duck_num), 32'd1);
      #5 Reset_n = 1'b0;
      #1 check("async reset duck_num", 32'(bus.duck_num), 32'd0);
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);

      // Round: ducks 0, 2, 4 hit
      pulse_start();
      fly_fire(10, 1'b1);
      check("hit0 active", 32'(bus.duck_active), 32'd0);
      check("hit0 falling", 32'(bus.duck_falling), 32'd1);
      check("hit0 hit_count", 32'(bus.hit_count), 32'd1);
      check("hit0 hit_map", 32'(bus.hit_map), 32'd1);
      check("hit0 shots_left", 32'(bus.shots_left), 32'd3);
      measure(2, "falling ticks", 90);
      measure(0, "duck1 fly ticks", 300);
      fly_fire(300, 1'b1);
      check("hit at expiry falling", 32'(bus.duck_falling), 32'd1);
      check("hit at expiry escape", 32'(bus.duck_escape), 32'd0);
      check("hit at expiry count", 32'(bus.hit_count), 32'd2);
      three_miss(2);
      fly_fire(5, 1'b1);
      check("duck4 hit_count", 32'(bus.hit_count), 32'd3);
      for (int d = 5; d < DUCKS; d++) three_miss(3);
      wait_sig(3, "round done");
      check("done hit_count", 32'(bus.hit_count), 32'd3);
      check("done hit_map", 32'(bus.hit_map), 32'(10'b0000010101));
      check("done duck_num", 32'(bus.duck_num), 32'd9);
      repeat (5) @(negedge Clk);
      check("done holds", 32'(bus.round_done), 32'd1);

      // Restart from DONE; start held an extra cycle is ignored in LAUNCH
      bus.start = 1'b1;
      @(negedge Clk);
      check("restart duck_num", 32'(bus.duck_num), 32'd0);
      check("restart hit_count", 32'(bus.hit_count), 32'd0);
      check("restart hit_map", 32'(bus.hit_map), 32'd0);
      check("restart spawn", 32'(bus.duck_spawn), 32'd1);
      check("restart round_done", 32'(bus.round_done), 32'd0);
      @(negedge Clk);
      bus.start = 1'b0;

      // Reset asserted mid-FALL, off the clock edge
      fly_fire(10, 1'b1);
      repeat (200) @(negedge Clk);
      check("in fall before reset", 32'(bus.duck_falling), 32'd1);
      #3 Reset_n = 1'b0;
      #1;
      check("mid-fall reset falling", 32'(bus.duck_falling), 32'd0);
      check("mid-fall reset hit_count", 32'(bus.hit_count), 32'd0);
      check("mid-fall reset hit_map", 32'(bus.hit_map), 32'd0);
      check("mid-fall reset shots", 32'(bus.shots_left), 32'd3);
`ifdef DUCK_SCORE_EN
      check("mid-fall reset score", 32'(bus.score), 32'd0);
`endif
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);

      // Perfect round
      pulse_start();
      for (int d = 0; d < DUCKS; d++) fly_fire(1, 1'b1);
      wait_sig(3, "perfect round done");
      check("perfect hit_count", 32'(bus.hit_count), 32'd10);
      check("perfect hit_map", 32'(bus.hit_map), 32'(10'b1111111111));
`ifdef DUCK_SCORE_EN
      @(negedge Clk);
      check("perfect score", 32'(bus.score), 32'd6000);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #4000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
